apb_master: RTL and testbench

- APB requester: turns a simple valid/ready command from the system side into APB SETUP/ACCESS transfers.
- Drives the select lines for the UART and TIMER slaves, which feed the APB slave mux. Consumes the mux's muxed PREADY/PRDATA/PSLVERR.
- Decodes the slave from the upper address bits and returns one response per command.
- Bounds every transfer with a PREADY timeout.

---
 rtl/apb_master.sv | 140 ++++++++++++++
 tb/tb_apb_master.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// APB requester: converts a valid/ready command into APB SETUP/ACCESS transfers
// for the UART and TIMER slaves, with address decode and a PREADY timeout.
module apb_master #(
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  PSEL_UART,
  output logic                  PSEL_TIMER,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  PREADY,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PSLVERR
);

  localparam int CW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int TC_M1 = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CW-1:0] TLAST = TC_M1[CW-1:0];

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, ERR} state_t;

  state_t                state, state_n;
  logic                  psel_uart_n, psel_timer_n, penable_n, pwrite_n;
  logic [ADDR_WIDTH-1:0] paddr_n;
  logic [DATA_WIDTH-1:0] pwdata_n, rsp_rdata_n;
  logic                  rsp_valid_n, rsp_err_n;
  logic [CW-1:0]         tcnt, tcnt_n;
  logic                  timed_out;

  assign cmd_ready = (state == IDLE);
  // Counter holds the index of the current ACCESS cycle; the last allowed one aborts.
  assign timed_out = (TIMEOUT_CYCLES != 0) && (tcnt == TLAST);

  always_comb begin
    state_n      = state;
    psel_uart_n  = PSEL_UART;
    psel_timer_n = PSEL_TIMER;
    penable_n    = PENABLE;
    pwrite_n     = PWRITE;
    paddr_n      = PADDR;
    pwdata_n     = PWDATA;
    rsp_valid_n  = 1'b0;
    rsp_rdata_n  = rsp_rdata;
    rsp_err_n    = rsp_err;
    tcnt_n       = tcnt;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          paddr_n  = cmd_addr;
          pwrite_n = cmd_write;
          pwdata_n = cmd_wdata;
          if (cmd_addr[ADDR_WIDTH-1]) begin
            state_n = ERR;
          end else begin
            psel_uart_n  = ~cmd_addr[ADDR_WIDTH-2];
            psel_timer_n = cmd_addr[ADDR_WIDTH-2];
            penable_n    = 1'b0;
            state_n      = SETUP;
          end
        end
      end
      SETUP: begin
        penable_n = 1'b1;
        tcnt_n    = '0;
        state_n   = ACCESS;
      end
      ACCESS: begin
        // PREADY is checked first so a completion on the limit cycle is not an error.
        if (PREADY) begin
          psel_uart_n  = 1'b0;
          psel_timer_n = 1'b0;
          penable_n    = 1'b0;
          rsp_valid_n  = 1'b1;
          rsp_err_n    = PSLVERR;
          rsp_rdata_n  = PWRITE ? '0 : PRDATA;
          state_n      = IDLE;
        end else if (timed_out) begin
          psel_uart_n  = 1'b0;
          psel_timer_n = 1'b0;
          penable_n    = 1'b0;
          rsp_valid_n  = 1'b1;
          rsp_err_n    = 1'b1;
          rsp_rdata_n  = '0;
          state_n      = IDLE;
        end else begin
          tcnt_n = tcnt + CW'(1);
        end
      end
      ERR: begin
        rsp_valid_n = 1'b1;
        rsp_err_n   = 1'b1;
        rsp_rdata_n = '0;
        state_n     = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state      <= IDLE;
      PSEL_UART  <= 1'b0;
      PSEL_TIMER <= 1'b0;
      PENABLE    <= 1'b0;
      PWRITE     <= 1'b0;
      PADDR      <= '0;
      PWDATA     <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      tcnt       <= '0;
    end else begin
      state      <= state_n;
      PSEL_UART  <= psel_uart_n;
      PSEL_TIMER <= psel_timer_n;
      PENABLE    <= penable_n;
      PWRITE     <= pwrite_n;
      PADDR      <= paddr_n;
      PWDATA     <= pwdata_n;
      rsp_valid  <= rsp_valid_n;
      rsp_rdata  <= rsp_rdata_n;
      rsp_err    <= rsp_err_n;
      tcnt       <= tcnt_n;
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: table of single transfers with a behavioural slave,
// plus back-to-back and mid-transfer reset sequences.
module tb_apb_master;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [9:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        PSEL_UART, PSEL_TIMER, PENABLE, PWRITE;
  logic [9:0]  PADDR;
  logic [31:0] PWDATA;
  logic        PREADY, PSLVERR;
  logic [31:0] PRDATA;

  int checks = 0;
  int errors = 0;

  always #5 PCLK = ~PCLK;

  apb_master #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL_UART(PSEL_UART), .PSEL_TIMER(PSEL_TIMER), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // exp_sel: 0 none, 1 UART, 2 TIMER. wait_n: ACCESS cycles with PREADY low.
  typedef struct {
    logic        write;
    logic [9:0]  addr;
    logic [31:0] wdata;
    int          wait_n;
    logic [31:0] prdata;
    logic        slverr;
    int          exp_sel;
    int          exp_lat;
    int          exp_en;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[9];

  task automatic run_vec(input int idx, input vec_t v);
    int cyc = 0, acc_idx = 0, sel_cyc = 0, en_cyc = 0;
    bit bad_sel = 0, unstable = 0, done = 0;
    int exp_sel_cyc;
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr; cmd_wdata = v.wdata;
    PREADY = 1'b0; PRDATA = 32'h0; PSLVERR = 1'b0;
    chk($sformatf("v%0d_cmd_ready_idle", idx), {31'h0, cmd_ready}, 32'd1);
    @(posedge PCLK);
    while (!done && cyc < 40) begin
      @(negedge PCLK);
      cyc++;
      cmd_valid = 1'b0;
      if (PSEL_UART && PSEL_TIMER) bad_sel = 1;
      if ((PSEL_UART && v.exp_sel != 1) || (PSEL_TIMER && v.exp_sel != 2)) bad_sel = 1;
      if (PENABLE && !(PSEL_UART || PSEL_TIMER)) bad_sel = 1;
      if (PSEL_UART || PSEL_TIMER) begin
        sel_cyc++;
        if (PADDR !== v.addr || PWDATA !== v.wdata || PWRITE !== v.write) unstable = 1;
      end
      if (PENABLE) begin
        en_cyc++;
        if (acc_idx >= v.wait_n) begin
          PREADY = 1'b1; PRDATA = v.prdata; PSLVERR = v.slverr;
        end else begin
          PREADY = 1'b0; PRDATA = 32'h5A5A5A5A; PSLVERR = 1'b1;
        end
        acc_idx++;
      end else begin
        PREADY = 1'b0; PRDATA = 32'h0; PSLVERR = 1'b0;
      end
      if (rsp_valid) done = 1;
    end
    exp_sel_cyc = (v.exp_sel == 0) ? 0 : v.exp_lat - 1;
    chk($sformatf("v%0d_rsp_seen", idx), {31'h0, done}, 32'd1);
    chk($sformatf("v%0d_latency", idx), cyc, v.exp_lat);
    chk($sformatf("v%0d_rsp_err", idx), {31'h0, rsp_err}, {31'h0, v.exp_err});
    chk($sformatf("v%0d_rsp_rdata", idx), rsp_rdata, v.exp_rdata);
    chk($sformatf("v%0d_psel_cycles", idx), sel_cyc, exp_sel_cyc);
    chk($sformatf("v%0d_penable_cycles", idx), en_cyc, v.exp_en);
    chk($sformatf("v%0d_psel_legal", idx), {31'h0, bad_sel}, 32'd0);
    chk($sformatf("v%0d_addr_data_stable", idx), {31'h0, unstable}, 32'd0);
    chk($sformatf("v%0d_cmd_ready_on_rsp", idx), {31'h0, cmd_ready}, 32'd1);
    @(negedge PCLK);
    chk($sformatf("v%0d_rsp_pulse_one", idx), {31'h0, rsp_valid}, 32'd0);
    chk($sformatf("v%0d_rdata_hold", idx), rsp_rdata, v.exp_rdata);
    chk($sformatf("v%0d_err_hold", idx), {31'h0, rsp_err}, {31'h0, v.exp_err});
    chk($sformatf("v%0d_paddr_retain", idx), {22'h0, PADDR}, {22'h0, v.addr});
  endtask

  initial begin
    int n_acc, n_rsp, acc_cyc[3];
    bit seen;

    vecs[0] = '{1'b0, 10'h004, 32'h00000000, 0,  32'hDEADBEEF, 1'b0, 1, 3,  1,  1'b0, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 10'h108, 32'h12345678, 3,  32'hFFFF0000, 1'b0, 2, 6,  4,  1'b0, 32'h00000000};
    vecs[2] = '{1'b0, 10'h010, 32'h0000000F, 0,  32'hAAAA5555, 1'b1, 1, 3,  1,  1'b1, 32'hAAAA5555};
    vecs[3] = '{1'b0, 10'h300, 32'h00000000, 0,  32'h11111111, 1'b0, 0, 2,  0,  1'b1, 32'h00000000};
    vecs[4] = '{1'b0, 10'h140, 32'h00000000, 99, 32'h22222222, 1'b0, 2, 18, 16, 1'b1, 32'h00000000};
    vecs[5] = '{1'b1, 10'h200, 32'hCAFEF00D, 0,  32'h33333333, 1'b0, 0, 2,  0,  1'b1, 32'h00000000};
    vecs[6] = '{1'b0, 10'h0FC, 32'h00000000, 2,  32'h0BADF00D, 1'b0, 1, 5,  3,  1'b0, 32'h0BADF00D};
    vecs[7] = '{1'b0, 10'h1F0, 32'h00000000, 15, 32'h76543210, 1'b0, 2, 18, 16, 1'b0, 32'h76543210};
    vecs[8] = '{1'b1, 10'h1FC, 32'hA5A5A5A5, 1,  32'h44444444, 1'b1, 2, 4,  2,  1'b1, 32'h00000000};

    // Reset state
    PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
    repeat (2) @(negedge PCLK);
    chk("reset_outputs",
        {20'h0, PSEL_UART, PSEL_TIMER, PENABLE, PWRITE, rsp_valid, rsp_err, 6'h0},
        32'h0);
    chk("reset_paddr", {22'h0, PADDR}, 32'h0);
    chk("reset_pwdata", PWDATA, 32'h0);
    chk("reset_rdata", rsp_rdata, 32'h0);
    chk("reset_cmd_ready", {31'h0, cmd_ready}, 32'd1);
    PRESET = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Back-to-back reads with cmd_valid held high
    n_acc = 0; n_rsp = 0;
    PREADY = 1'b1; PSLVERR = 1'b0;
    for (int c = 0; c < 30 && n_rsp < 3; c++) begin
      @(negedge PCLK);
      if (rsp_valid) begin
        chk($sformatf("b2b_rdata%0d", n_rsp), rsp_rdata, 32'hC0DE0000 | (32'd4 * n_rsp));
        n_rsp++;
      end
      cmd_write = 1'b0; cmd_wdata = '0;
      cmd_addr  = 10'(4 * n_acc);
      cmd_valid = (n_acc < 3);
      PRDATA = 32'hC0DE0000 | {22'h0, PADDR};
      if (cmd_valid && cmd_ready) begin
        acc_cyc[n_acc] = c;
        n_acc++;
      end
    end
    cmd_valid = 1'b0;
    chk("b2b_accepts", n_acc, 3);
    chk("b2b_responses", n_rsp, 3);
    chk("b2b_gap01", acc_cyc[1] - acc_cyc[0], 3);
    chk("b2b_gap12", acc_cyc[2] - acc_cyc[1], 3);

    // Reset during ACCESS
    @(negedge PCLK);
    PREADY = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 10'h100;
    @(posedge PCLK);
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge PCLK);
      cmd_valid = 1'b0;
      if (PENABLE) seen = 1;
    end
    chk("rst_reached_access", {31'h0, seen}, 32'd1);
    @(negedge PCLK);
    #1 PRESET = 1'b1;
    #1;
    chk("rst_async_psel", {30'h0, PSEL_UART, PSEL_TIMER}, 32'd0);
    chk("rst_async_penable", {31'h0, PENABLE}, 32'd0);
    repeat (2) @(negedge PCLK);
    PRESET = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge PCLK);
      if (rsp_valid) seen = 1;
    end
    chk("rst_no_rsp", {31'h0, seen}, 32'd0);
    chk("rst_cmd_ready", {31'h0, cmd_ready}, 32'd1);
    chk("rst_rdata_cleared", rsp_rdata, 32'h0);
    chk("rst_idle_psel", {29'h0, PSEL_UART, PSEL_TIMER, PENABLE}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
